// File: rtl/vga_scan_generator.sv
// VGA raster timing source: 25 MHz pixel enable derived from a 50 MHz clock,
// pixel/line counters, registered active-low syncs, blanking and scan strobes.
module vga_scan_generator #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic       CLK,
  input  logic       Reset,
  output logic [9:0] VGA_X,
  output logic [9:0] VGA_Y,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       pixel_tick,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] H_LAST    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END = 10'(V_VIS);
  localparam logic [9:0] HS_BEG    = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG    = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_VIS + V_FP + V_SYNC);

  logic       ph;
  logic [9:0] hc, vc;
  logic [9:0] hc_nxt, vc_nxt;
  logic       h_wrap, f_wrap;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hc_nxt = hc;
    vc_nxt = vc;
    h_wrap = ph && (hc == H_LAST);
    f_wrap = h_wrap && (vc == V_LAST);
    if (ph) begin
      hc_nxt = h_wrap ? 10'd0 : hc + 10'd1;
      if (h_wrap) begin
        vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end
    end
  end

  // Syncs and blank are derived from the next-state counters so they land on
  // the same edge as the coordinates they describe.
  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ph          <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      frame_count <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ph          <= ~ph;
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      VGA_HS      <= !((hc_nxt >= HS_BEG) && (hc_nxt < HS_END));
      VGA_VS      <= !((vc_nxt >= VS_BEG) && (vc_nxt < VS_END));
      VGA_BLANK_N <= (hc_nxt < H_VIS_END) && (vc_nxt < V_VIS_END);
      // Strobes fire only on an actual wrap, so the reset-produced (0,0) never pulses.
      line_start  <= h_wrap;
      frame_start <= f_wrap;
      if (f_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign VGA_X      = hc;
  assign VGA_Y      = vc;
  assign pixel_tick = ph;
  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Directed bench: a shrunken-timing instance exercises full frames and the
// 256-frame wrap; a default-timing instance checks the real horizontal line.
module tb_vga_scan_generator;

  // Small timing: line = 15 pixels (HS at 10..12), frame = 8 lines (VS at 5..6).
  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FRAME_CLK = HT * VT * 2;  // 240

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [9:0] s_x, s_y, d_x, d_y;
  logic       s_hs, s_vs, s_blank, s_sync, s_tick, s_ls, s_fs;
  logic       d_hs, d_vs, d_blank, d_sync, d_tick, d_ls, d_fs;
  logic [7:0] s_fc, d_fc;

  int checks = 0;
  int errors = 0;

  vga_scan_generator #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .CLK(clk), .Reset(rst), .VGA_X(s_x), .VGA_Y(s_y), .VGA_HS(s_hs),
    .VGA_VS(s_vs), .VGA_BLANK_N(s_blank), .VGA_SYNC_N(s_sync),
    .pixel_tick(s_tick), .line_start(s_ls), .frame_start(s_fs),
    .frame_count(s_fc)
  );

  vga_scan_generator u_dflt (
    .CLK(clk), .Reset(rst), .VGA_X(d_x), .VGA_Y(d_y), .VGA_HS(d_hs),
    .VGA_VS(d_vs), .VGA_BLANK_N(d_blank), .VGA_SYNC_N(d_sync),
    .pixel_tick(d_tick), .line_start(d_ls), .frame_start(d_fs),
    .frame_count(d_fc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ex, ey, pix, efc;
    logic ehs, evs, eblank, els, efs, first;
    int sync_bad, fc_bad, fs_cnt, fs_gap_bad, last_fs;
    int d_hs_cnt, d_hs_bad, d_ls_cnt, d_fall_seen, prev_dx, prev_blank;
    int n, found;

    sync_bad = 0; fc_bad = 0; fs_cnt = 0; fs_gap_bad = 0; last_fs = -1;
    d_hs_cnt = 0; d_hs_bad = 0; d_ls_cnt = 0; d_fall_seen = 0;
    prev_dx = 0; prev_blank = 1;

    // Reset state of both instances.
    #12;
    check("rst_x", s_x, 0);          check("rst_y", s_y, 0);
    check("rst_hs", s_hs, 1);        check("rst_vs", s_vs, 1);
    check("rst_blank", s_blank, 1);  check("rst_sync", s_sync, 0);
    check("rst_tick", s_tick, 0);    check("rst_ls", s_ls, 0);
    check("rst_fs", s_fs, 0);        check("rst_fc", s_fc, 0);
    check("rst_d_hs", d_hs, 1);      check("rst_d_blank", d_blank, 1);

    // Mid-line reset on the default instance at hc=300, ph=1.
    step();
    rst = 1'b0;
    repeat (601) step();
    check("midline_pre_x", d_x, 300);
    check("midline_pre_tick", d_tick, 1);
    #1 rst = 1'b1;
    #1;
    check("midline_x", d_x, 0);       check("midline_y", d_y, 0);
    check("midline_hs", d_hs, 1);     check("midline_blank", d_blank, 1);
    check("midline_tick", d_tick, 0);
    step();
    rst = 1'b0;

    // Main run: 256 small frames, k = CLK edges since release.
    for (int k = 0; k <= 256 * FRAME_CLK; k++) begin
      if (k > 0) step();
      pix    = k / 2;
      ex     = pix % HT;
      ey     = (pix / HT) % VT;
      efc    = (pix / (HT * VT)) % 256;
      first  = (k % 2 == 0) && (k > 0);
      ehs    = !(ex >= 10 && ex < 13);
      evs    = !(ey >= 5 && ey < 7);
      eblank = (ex < 8) && (ey < 4);
      els    = first && (ex == 0);
      efs    = els && (ey == 0);

      if (k < 2 * FRAME_CLK) begin
        check("x", s_x, ex);            check("y", s_y, ey);
        check("hs", s_hs, ehs);         check("vs", s_vs, evs);
        check("blank", s_blank, eblank); check("tick", s_tick, k % 2);
        check("line_start", s_ls, els); check("frame_start", s_fs, efs);
        check("frame_count", s_fc, efc); check("sync_n", s_sync, 0);
      end else begin
        if (s_hs !== ehs || s_vs !== evs) sync_bad++;
        if (s_fc !== 8'(efc)) fc_bad++;
      end

      if (s_fs === 1'b1) begin
        fs_cnt++;
        if (last_fs >= 0 && k - last_fs != FRAME_CLK) fs_gap_bad++;
        last_fs = k;
      end

      if (k < 6) check("d_x_seq", d_x, k / 2);
      if (k <= 1600) begin
        if (d_hs === 1'b0) begin
          d_hs_cnt++;
          if (d_x < 656 || d_x > 751) d_hs_bad++;
        end
        if (k > 0 && d_ls === 1'b1) d_ls_cnt++;
        if (prev_dx == 639 && d_x == 640) begin
          d_fall_seen = 1;
          check("d_blank_before_fall", prev_blank, 1);
          check("d_blank_fall", d_blank, 0);
        end
        prev_dx    = d_x;
        prev_blank = d_blank;
      end

      if (k == 256 * FRAME_CLK - 1) check("fc_255", s_fc, 255);
      if (k == 256 * FRAME_CLK) begin
        check("fc_wrap", s_fc, 0);
        check("wrap_fs", s_fs, 1);
        check("wrap_x", s_x, 0);
        check("wrap_y", s_y, 0);
      end
    end

    check("sync_glitches", sync_bad, 0);
    check("fc_track", fc_bad, 0);
    check("fs_count", fs_cnt, 256);
    check("fs_spacing", fs_gap_bad, 0);
    check("d_hs_low_clk", d_hs_cnt, 192);
    check("d_hs_window", d_hs_bad, 0);
    check("d_line_starts", d_ls_cnt, 1);
    check("d_blank_fall_seen", d_fall_seen, 1);

    // Reset during the last VS line (vc=6), then time to the first frame_start.
    repeat (192) step();
    check("vs_pre_y", s_y, 6);
    check("vs_pre_low", s_vs, 0);
    #1 rst = 1'b1;
    #1;
    check("vs_async_high", s_vs, 1);
    check("vs_rst_y", s_y, 0);
    check("vs_rst_fc", s_fc, 0);
    check("vs_rst_fs", s_fs, 0);
    step();
    rst = 1'b0;
    n = 0;
    found = 0;
    while (n < 1000 && found == 0) begin
      step();
      n++;
      if (s_fs === 1'b1) found = 1;
    end
    check("fs_after_release", n, FRAME_CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_generator.md
# vga_scan_generator

Raster timing source that drives the pixel coordinates and sync signals consumed by the colour mapper and the VGA DAC. It runs from the 50 MHz system clock and makes a 25 MHz pixel-enable. It scans a 640x480 frame at 60 Hz, outputting VGA_X/VGA_Y, active-low syncs and blanking. It also gives per-line and per-frame strobes, so downstream pixel-indexed memories and overlays stay aligned to the scan.

## Interface
Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- CLK  in  1  system clock, 50 MHz; all state is updated on its rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- VGA_X  out  10  current horizontal count, 0..H_TOTAL-1
- VGA_Y  out  10  current vertical count, 0..V_TOTAL-1
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high only inside the visible region
- VGA_SYNC_N  out  1  tied to 0 (no sync-on-green)
- pixel_tick  out  1  one-CLK pulse; the coordinates advance on the CLK edge ending this cycle
- line_start  out  1  one-CLK pulse while VGA_X==0, on the first CLK of that pixel
- frame_start  out  1  one-CLK pulse while (VGA_X,VGA_Y)==(0,0), on the first CLK of that pixel
- frame_count  out  8  number of completed frames, wrapping modulo 256

## Operation
- Derived totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL likewise (525 by default).
- Phase bit `ph`:
  - toggles on every CLK;
  - pixel_tick = ph.
- Horizontal counter hc:
  - on pixel_tick, hc increments;
  - at H_TOTAL-1 it wraps to 0.
- Vertical counter vc:
  - increments only when hc wraps;
  - wraps to 0 at V_TOTAL-1.
- frame_count increments when both counters wrap together.
- VGA_X = hc and VGA_Y = vc, driven directly from the registers. Values are not clipped, so consumers must gate on VGA_BLANK_N.
- Sync and blank outputs are registered. Each is computed from the next-state counters, so it changes on the same edge as VGA_X/VGA_Y:
  - VGA_HS = 0 when H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC (656..751 by default);
  - VGA_VS = 0 when V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (490..491 by default);
  - VGA_BLANK_N = (hc < H_VIS) && (vc < V_VIS).
- line_start and frame_start are registered and asserted on the CLK edge where the counters enter the qualifying value. They are never asserted for two consecutive CLKs.
- Counter widths: all comparisons are 10-bit unsigned, and the counters never reach 1024.
- Reset (asynchronous, any time, including mid-line or mid-sync pulse) drives:
  - ph=0, hc=0, vc=0, frame_count=0;
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=1, VGA_SYNC_N=0;
  - pixel_tick=0, line_start=0, frame_start=0.
- On Reset release there is no extra frame_start for the (0,0) pixel that reset produced. The first frame_start comes at the start of the next frame.

## Timing
- Each coordinate is held for exactly 2 CLKs.
- After Reset is released:
  - first CLK edge: ph goes 0 -> 1;
  - second CLK edge: hc becomes 1.
- Line period is 1600 CLK; frame period is 840000 CLK.
- Output latency: VGA_HS, VGA_VS and VGA_BLANK_N are 0 CLK relative to VGA_X/VGA_Y. They transition on the same edge.
- Downstream colour logic adds its own pipeline delay. This block provides no compensation for it.

## Test plan
- Reset mid-line: assert Reset while hc=300 and ph=1 -> in the same cycle hc=0, vc=0, VGA_HS=1, VGA_BLANK_N=1. After release, VGA_X reads 0,0,1,1,2,2 on successive CLKs.
- Horizontal timing: run one line -> VGA_HS is low exactly for VGA_X 656..751 (192 CLK). VGA_BLANK_N falls on the edge where VGA_X goes 639 -> 640. line_start pulses once per 1600 CLK.
- Vertical timing: run one full frame -> VGA_VS is low only for VGA_Y 490..491 (3200 CLK). VGA_BLANK_N stays low for all of VGA_Y 480..524.
- Wrap: at (799,524) on pixel_tick -> the next values are (0,0), frame_start pulses once, and frame_count goes 0 -> 1. frame_start pulses are spaced exactly 840000 CLK apart.
- frame_count wrap: run 256 frames -> frame_count returns to 0 with no glitch on the syncs.
- Reset during VGA_VS pulse: assert Reset at vc=491 -> VGA_VS returns to 1 asynchronously. No frame_start pulse appears until 840000 CLK after release.
